// File: rtl/sigma_delta_parallel_if.sv
// Sample-in / bitstream-out handshake bundle for sigma_delta_parallel.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface sigma_delta_parallel_if #(
  parameter int WIDTH  = 8,
  parameter int OUTLEN = 16
);
  logic signed [WIDTH-1:0]  inData;
  logic                     inValid;
  logic                     inReady;
  logic        [OUTLEN-1:0] outData;
  logic                     outValid;
  logic                     outReady;

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outValid
  );

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outValid
  );
endinterface

// File: rtl/sigma_delta_parallel.sv
// First-order sigma-delta modulator emitting OUTLEN bits per clock from one signed WIDTH-bit sample.
// Optional dither LFSR is built when SIGMA_DELTA_DITHER_EN is defined.
module sigma_delta_parallel #(
  parameter int WIDTH  = 8,
  parameter int OUTLEN = 16,
  parameter int UCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  sigma_delta_parallel_if.slave bus,
  output logic [UCNT_W-1:0]     underrun
);

  function automatic logic [OUTLEN-1:0] alt_word();
    logic [OUTLEN-1:0] w;
    w = '0;
    for (int k = 0; k < OUTLEN; k++) w[k] = k[0];
    return w;
  endfunction

  localparam logic [OUTLEN-1:0] RESET_WORD = alt_word();

  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  hold;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  u;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  acc_next;
  logic [OUTLEN-1:0] word;
  logic              gen;

  // A new word is produced whenever the output register is free or being emptied this edge.
  assign gen         = en && (!bus.outValid || bus.outReady);
  assign bus.inReady = gen;

  assign x = bus.inValid ? bus.inData : hold;
  assign u = {~x[WIDTH-1], x[WIDTH-2:0]};

`ifdef SIGMA_DELTA_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (gen) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign a0 = acc ^ {{(WIDTH-1){1'b0}}, lfsr[0]};
`else
  assign a0 = acc;
`endif

  // Unrolled accumulate chain: each carry out of the WIDTH-bit add is one output bit.
  always_comb begin
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   sum;
    a        = a0;
    sum      = '0;
    word     = '0;
    for (int k = 0; k < OUTLEN; k++) begin
      sum     = {1'b0, a} + {1'b0, u};
      word[k] = sum[WIDTH];
      a       = sum[WIDTH-1:0];
    end
    acc_next = a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      hold         <= '0;
      bus.outData  <= RESET_WORD;
      bus.outValid <= 1'b0;
      underrun     <= '0;
    end else if (gen) begin
      acc          <= acc_next;
      bus.outData  <= word;
      bus.outValid <= 1'b1;
      if (bus.inValid) begin
        hold <= bus.inData;
      end else if (underrun != {UCNT_W{1'b1}}) begin
        underrun <= underrun + 1'b1;
      end
    end else if (bus.outValid && bus.outReady) begin
      bus.outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigma_delta_parallel.sv
// Randomized and directed bench for sigma_delta_parallel against a bit-serial arithmetic reference model.
module tb_sigma_delta_parallel;
  localparam int WIDTH  = 8;
  localparam int OUTLEN = 16;
  localparam int UCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [UCNT_W-1:0] underrun;

  sigma_delta_parallel_if #(.WIDTH(WIDTH), .OUTLEN(OUTLEN)) bus ();

  sigma_delta_parallel #(.WIDTH(WIDTH), .OUTLEN(OUTLEN), .UCNT_W(UCNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_acc;
  int          m_hold;
  int          m_ucnt;
  int          m_acc_before;
  int          m_u;
  logic        m_ov;
  logic [15:0] m_od;
  logic        exp_ready;
  logic        obs_ready;

  task automatic model_reset();
    m_acc  = 0;
    m_hold = 0;
    m_ucnt = 0;
    m_ov   = 1'b0;
    m_od   = 16'hAAAA;
  endtask

  // Drive one clock of inputs, capture inReady before the edge, update the model after it.
  task automatic tick(input logic e, input int d, input logic v, input logic r);
    int x;
    int a;
    logic [15:0] w;
    en           = e;
    bus.inData   = d[7:0];
    bus.inValid  = v;
    bus.outReady = r;
    #2;
    obs_ready = bus.inReady;
    exp_ready = e && (!m_ov || r);
    @(posedge clk);
    #1;
    if (exp_ready) begin
      if (v) begin
        x      = d;
        m_hold = d;
      end else begin
        x = m_hold;
        if (m_ucnt < 255) m_ucnt++;
      end
      m_u          = x + 128;
      m_acc_before = m_acc;
      a            = m_acc;
      for (int k = 0; k < OUTLEN; k++) begin
        a    = a + m_u;
        w[k] = (a >= 256);
        a    = a % 256;
      end
      m_acc = a;
      m_od  = w;
      m_ov  = 1'b1;
    end else if (m_ov && r) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    en           = 1'b0;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.outReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic test_reset();
    en = 1'b0; bus.inValid = 1'b0; bus.inData = '0; bus.outReady = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", bus.outValid); end
    n_cmp++; if (bus.outData !== 16'hAAAA) begin n_fail++; $display("FAIL reset_outdata: got %h expected aaaa", bus.outData); end
    n_cmp++; if (underrun !== 8'd0) begin n_fail++; $display("FAIL reset_underrun: got %0d expected 0", underrun); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    en = 1'b1;
    #1;
    n_cmp++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", bus.inReady); end
    en = 1'b0;
  endtask

  task automatic test_zero();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 0, 1'b1, 1'b1);
      n_cmp++; if (bus.outData !== 16'hAAAA) begin n_fail++; $display("FAIL zero_word: got %h expected aaaa", bus.outData); end
      n_cmp++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", bus.outValid); end
      n_cmp++; if (underrun !== 8'd0) begin n_fail++; $display("FAIL zero_underrun: got %0d expected 0", underrun); end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, -128, 1'b1, 1'b1);
      n_cmp++; if (bus.outData !== 16'h0000) begin n_fail++; $display("FAIL min_word: got %h expected 0000", bus.outData); end
    end
    do_reset();
    tick(1'b1, 127, 1'b1, 1'b1);
    n_cmp++; if (bus.outData !== 16'hFFFE) begin n_fail++; $display("FAIL max_first_word: got %h expected fffe", bus.outData); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 127, 1'b1, 1'b1);
      n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL max_word: got %h expected %h", bus.outData, m_od); end
      n_cmp++;
      if ($countones(bus.outData) != (m_acc_before + OUTLEN * m_u) / 256) begin
        n_fail++; $display("FAIL max_popcount: got %0d expected %0d", $countones(bus.outData), (m_acc_before + OUTLEN * m_u) / 256);
      end
    end
  endtask

  task automatic test_starve();
    do_reset();
    tick(1'b1, 64, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, rand_sample(), 1'b0, 1'b1);
      n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL starve_word: got %h expected %h", bus.outData, m_od); end
      n_cmp++; if ($countones(bus.outData) != 12) begin n_fail++; $display("FAIL starve_popcount: got %0d expected 12", $countones(bus.outData)); end
    end
    n_cmp++; if (underrun !== 8'd10) begin n_fail++; $display("FAIL starve_underrun10: got %0d expected 10", underrun); end
    for (int i = 0; i < 300; i++) tick(1'b1, rand_sample(), 1'b0, 1'b1);
    n_cmp++; if (underrun !== 8'd255) begin n_fail++; $display("FAIL starve_saturate: got %0d expected 255", underrun); end
    n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL starve_long_word: got %h expected %h", bus.outData, m_od); end
  endtask

  task automatic test_backpressure();
    logic [15:0] saved;
    do_reset();
    tick(1'b1, rand_sample(), 1'b1, 1'b1);
    tick(1'b1, rand_sample(), 1'b1, 1'b1);
    saved = m_od;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, rand_sample(), 1'b1, 1'b0);
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_inready: got %b expected 0", obs_ready); end
      n_cmp++; if (bus.outData !== saved) begin n_fail++; $display("FAIL bp_hold_word: got %h expected %h", bus.outData, saved); end
      n_cmp++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", bus.outValid); end
    end
    tick(1'b1, 100, 1'b1, 1'b1);
    n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL bp_resume_word: got %h expected %h", bus.outData, m_od); end
    n_cmp++; if (underrun !== 8'd0) begin n_fail++; $display("FAIL bp_underrun: got %0d expected 0", underrun); end
  endtask

  task automatic test_enable();
    logic [15:0] saved;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, rand_sample(), 1'b1, 1'b1);
    saved = m_od;
    tick(1'b0, rand_sample(), 1'b1, 1'b1);
    n_cmp++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL en_drain: got %b expected 0", bus.outValid); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, rand_sample(), 1'b1, 1'($urandom_range(0, 1)));
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL en_inready: got %b expected 0", obs_ready); end
      n_cmp++; if (bus.outValid !== 1'b0 || bus.outData !== saved) begin
        n_fail++; $display("FAIL en_frozen: got %b/%h expected 0/%h", bus.outValid, bus.outData, saved);
      end
    end
    tick(1'b1, -37, 1'b1, 1'b1);
    n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL en_resume_word: got %h expected %h", bus.outData, m_od); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 77, 1'b1, 1'b1);
    tick(1'b1, 0, 1'b0, 1'b1);
    tick(1'b1, -5, 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", bus.outValid); end
    n_cmp++; if (bus.outData !== 16'hAAAA) begin n_fail++; $display("FAIL areset_word: got %h expected aaaa", bus.outData); end
    n_cmp++; if (underrun !== 8'd0) begin n_fail++; $display("FAIL areset_underrun: got %0d expected 0", underrun); end
    en = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    tick(1'b1, 0, 1'b1, 1'b1);
    n_cmp++; if (bus.outData !== 16'hAAAA) begin n_fail++; $display("FAIL areset_first_word: got %h expected aaaa", bus.outData); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 9) != 0), rand_sample(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_inready: got %b expected %b at %0d", obs_ready, exp_ready, i); end
      n_cmp++; if (bus.outValid !== m_ov) begin n_fail++; $display("FAIL rnd_outvalid: got %b expected %b at %0d", bus.outValid, m_ov, i); end
      n_cmp++; if (bus.outData !== m_od) begin n_fail++; $display("FAIL rnd_outdata: got %h expected %h at %0d", bus.outData, m_od, i); end
      n_cmp++; if (underrun !== 8'(m_ucnt)) begin n_fail++; $display("FAIL rnd_underrun: got %0d expected %0d at %0d", underrun, m_ucnt, i); end
    end
  endtask

  initial begin
    bus.inData   = '0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    model_reset();
    test_reset();
    test_zero();
    test_extremes();
    test_starve();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_delta_parallel.md
# sigma_delta_parallel

Parametrised first-order sigma-delta modulator that emits OUTLEN output bits per clock from one WIDTH-bit signed sample. Successor to the fixed lookup-table fast modulator: the modulation chain is computed arithmetically (unrolled adder chain), so WIDTH and OUTLEN are independent. It adds valid/ready handshakes on both sides, sample-and-hold on input starvation, and an underrun counter. It sits between the DSP sample pipeline and the serialiser/DAC driver.

## Interface
- WIDTH, 8: input sample width, signed, ≥2.
- OUTLEN, 16: output bits per word, even, ≥2.
- UCNT_W, 8: underrun counter width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; low freezes all state except output drain.
- inData  in  WIDTH  signed input sample.
- inValid  in  1  inData valid.
- inReady  out  1  sample accepted when inValid && inReady.
- outData  out  OUTLEN  bitstream word, LSB = first sample in time.
- outValid  out  1  outData valid.
- outReady  in  1  downstream accepts outData.
- underrun  out  UCNT_W  saturating count of words generated from a held sample.

## Operation
- Offset input: u = {~x[WIDTH-1], x[WIDTH-2:0]} (unsigned, 0..2^WIDTH-1), x = sample in use.
- Accumulator acc: WIDTH-bit unsigned register. Per word, for k = 0..OUTLEN-1: {bit_k, a_{k+1}} = a_k + u, a_0 = acc; outData[k] = bit_k; acc ← a_OUTLEN.
- Word count identity: popcount(word) = floor((acc + OUTLEN·u) / 2^WIDTH).
- gen = en && (!outValid || outReady). inReady = gen (combinational).
- On gen: if inValid, x = inData (bypass, used this cycle) and hold ← inData; else x = hold, underrun increments (saturates at 2^UCNT_W-1).
- On gen: outData ← word, outValid ← 1, acc ← a_OUTLEN.
- If !gen && outValid && outReady: outValid ← 0 (drain while en low).
- Otherwise all registers hold. en low never drops a pending word.
- Underrun counter cleared only by reset.

## Timing
- Reset (async, rst_n low): acc = 0, hold = 0, outValid = 0, outData = alternating 10 pattern (bit0 = 0, bit1 = 1, …; 0xAAAA for OUTLEN=16), underrun = 0, LFSR = 16'hACE1 when dither built.
- Latency: accepted sample appears in outData the cycle after acceptance (1 cycle).
- Throughput: one word per clock with outReady held high.
- Backpressure: outValid && !outReady → inReady = 0, outData/acc stable.
- Simultaneous accept-and-consume: new word replaces old in same edge; outValid stays 1.
- Accumulator wraps modulo 2^WIDTH; carry is the output bit, never lost.
- Reset asserted mid-stream: immediate clear; first post-reset word starts from acc = 0.
- inReady is combinational from en, outValid, outReady; no combinational path inData→outputs.

## Configuration
- SIGMA_DELTA_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per gen; its bit 0 is XORed into acc[0] before the chain (a_0 = acc ^ lfsr[0]). Breaks idle tones; word popcount deviates from identity by at most 1.
- Undefined: no LFSR logic, a_0 = acc, fully deterministic. All directed tests below assume undefined.

## Test plan
- Reset then inData=0, inValid=1, outReady=1, en=1 (WIDTH=8, OUTLEN=16) → outData=0xAAAA every cycle, underrun=0.
- inData=-128 continuous → outData=0x0000; inData=127 from acc=0 → first word 0xFFFE (15 ones), subsequent popcounts track floor identity.
- Single sample 64 then inValid=0 for 10 words → words repeat from hold with popcount ≈ 12 per word, underrun=10; with UCNT_W=8 and 300 starved words → underrun saturates at 255.
- outReady=0 for 5 cycles with outValid=1 → inReady=0, outData and acc unchanged, no sample lost; outReady=1 → next word uses next accepted sample.
- en=0 with pending word and outReady=1 → outValid drops after one cycle, no new words, acc frozen; en=1 resumes with identical continuation.
- rst_n pulsed low asynchronously mid-word (between edges) → outputs at reset values immediately; first word after release with inData=0 is 0xAAAA.
